// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder.
package serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

  // Counter width for n slices; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder cell; the ripple adder is built from these.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/nibble_adder.sv
// 4-bit combinational ripple-carry adder made of full_adder_cell slices.
module nibble_adder
  import serial_adder_pkg::*;
(
  output logic [NIBBLE_W-1:0] sum,
  output logic                carry_out,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                carry_in
);
  logic [NIBBLE_W:0] c;

  assign c[0]      = carry_in;
  assign carry_out = c[NIBBLE_W];

  for (genvar g = 0; g < NIBBLE_W; g++) begin : g_bit
    full_adder_cell u_fa (
      .a (a[g]),
      .b (b[g]),
      .ci(c[g]),
      .s (sum[g]),
      .co(c[g+1])
    );
  end
endmodule

// File: rtl/serial_word_adder.sv
// Nibble-serial wide adder: one shared 4-bit adder walks the word LSB-first.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module serial_word_adder
  import serial_adder_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_in,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         ready,
  output logic [W-1:0] sum,
  output logic         carry_out,
  output logic         done
);
  localparam int IDX_W = clog2(NIBBLES);

  sa_state_t           state_q, state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [W-1:0]        a_q, b_q, sum_q;
  logic                carry_q, cout_q;
  logic                last;
  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
  logic                nib_co;
  logic                init_carry;
  logic                inv_b;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q;
  always_ff @(posedge clk or posedge reset)
    if (reset)                          sub_q <= 1'b0;
    else if (state_q == IDLE && start) sub_q <= sub;
  assign inv_b      = sub_q;
  // Two's complement: ~B plus an initial carry of one.
  assign init_carry = sub ? 1'b1 : carry_in;
`else
  assign inv_b      = 1'b0;
  assign init_carry = carry_in;
`endif

  assign last  = (idx_q == IDX_W'(NIBBLES - 1));
  assign nib_a = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{inv_b}};

  nibble_adder u_add (
    .sum      (nib_sum),
    .carry_out(nib_co),
    .a        (nib_a),
    .b        (nib_b),
    .carry_in (carry_q)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state_q == IDLE);
    done      = (state_q == DONE);
    sum       = sum_q;
    carry_out = cout_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q     <= a;
          b_q     <= b;
          carry_q <= init_carry;
          idx_q   <= '0;
        end
        RUN: begin
          sum_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W] <= nib_sum;
          carry_q <= nib_co;
          if (last) cout_q <= nib_co;
          else      idx_q  <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
